// File: rtl/m31_pkg.sv
// Shared M31 field definitions: modulus, canonical-form helper and the
// operand loader state encoding.
package m31_pkg;

    // Field modulus p = 2^31 - 1
    localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

    // Loader FSM states
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Reduce a raw 31-bit word to [0, p): only all-ones (== p == 0 mod p) needs folding
    function automatic logic [30:0] m31_canonical(input logic [30:0] word);
        logic [30:0] result;
        if (word == M31_P) begin
            result = 31'h0000_0000;
        end else begin
            result = word;
        end
        return result;
    endfunction

endpackage

// File: rtl/m31_canonicalize.sv
// Combinational single-word reducer into canonical M31 form. The all-ones
// word is congruent to zero and is mapped to zero; every other word passes.
module m31_canonicalize
    import m31_pkg::*;
#(
    parameter int WORD_WIDTH = 31
) (
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic [WORD_WIDTH-1:0] word_out
);

    generate
        if (WORD_WIDTH == 31) begin : g_m31
            assign word_out = m31_canonical(word_in);
        end else begin : g_generic
            assign word_out = (word_in == {WORD_WIDTH{1'b1}}) ? {WORD_WIDTH{1'b0}} : word_in;
        end
    endgenerate

endmodule

// File: rtl/vector_operand_loader.sv
// Operand loader feeding vector_dot_product: collects (a, b) lane pairs over
// a valid/ready stream into two register banks, zero-pads short vectors
// terminated by in_last, and holds the banks until the consumer drains them.
module vector_operand_loader
    import m31_pkg::*;
#(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WORD_WIDTH-1:0]              in_a,
    input  logic [WORD_WIDTH-1:0]              in_b,
    input  logic                               in_last,
    output logic [WORD_WIDTH-1:0]              vec1 [0:VECTOR_SIZE-1],
    output logic [WORD_WIDTH-1:0]              vec2 [0:VECTOR_SIZE-1],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(VECTOR_SIZE+1)-1:0]   out_len
);

    localparam int IDX_W = $clog2(VECTOR_SIZE);
    localparam int LEN_W = $clog2(VECTOR_SIZE + 1);

    localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [LEN_W-1:0]      LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]      LEN_ONE   = LEN_W'(1);
    localparam logic [WORD_WIDTH-1:0] LANE_ZERO = {WORD_WIDTH{1'b0}};

    loader_state_t           state_r;
    loader_state_t           state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_s;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        len_s;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    accept_s;
    logic                    drain_s;
    logic [WORD_WIDTH-1:0]   a_canon_s;
    logic [WORD_WIDTH-1:0]   b_canon_s;
    logic [VECTOR_SIZE-1:0]  lane_we_s;
    logic [WORD_WIDTH-1:0]   vec1_r [0:VECTOR_SIZE-1];
    logic [WORD_WIDTH-1:0]   vec2_r [0:VECTOR_SIZE-1];

    m31_canonicalize #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_canon_a (
        .word_in  (in_a),
        .word_out (a_canon_s)
    );

    m31_canonicalize #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_canon_b (
        .word_in  (in_b),
        .word_out (b_canon_s)
    );

    // Next-state, lane index and length decode; handshakes resolved from state only
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        len_s    = len_r;
        accept_s = 1'b0;
        drain_s  = 1'b0;
        case (state_r)
            FILL: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    idx_s    = idx_r + IDX_ONE;
                    if (in_last || (idx_r == IDX_LAST)) begin
                        state_s = FULL;
                        len_s   = LEN_W'(idx_r) + LEN_ONE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    drain_s = 1'b1;
                    state_s = FILL;
                    idx_s   = IDX_ZERO;
                    len_s   = LEN_ZERO;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = FILL;
                idx_s   = IDX_ZERO;
                len_s   = LEN_ZERO;
            end
        endcase
    end

    // One-hot lane write enables from the current fill index
    genvar g;
    generate
        for (g = 0; g < VECTOR_SIZE; g = g + 1) begin : g_lane
            assign lane_we_s[g] = accept_s && (idx_r == IDX_W'(g));
            assign vec1[g]      = vec1_r[g];
            assign vec2[g]      = vec2_r[g];
        end
    endgenerate

    // State, index, length and registered handshake flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= FILL;
            idx_r       <= IDX_ZERO;
            len_r       <= LEN_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            len_r       <= len_s;
            in_ready_r  <= (state_s == FILL);
            out_valid_r <= (state_s == FULL);
        end
    end

    // Operand banks: cleared on drain, written one lane per accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                vec1_r[i] <= LANE_ZERO;
                vec2_r[i] <= LANE_ZERO;
            end
        end else if (drain_s) begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                vec1_r[i] <= LANE_ZERO;
                vec2_r[i] <= LANE_ZERO;
            end
        end else begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                if (lane_we_s[i]) begin
                    vec1_r[i] <= a_canon_s;
                    vec2_r[i] <= b_canon_s;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_len   = len_r;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Self-checking bench for vector_operand_loader: table-driven directed
// vectors, hand-written multi-cycle sequences and randomized vectors checked
// against a transaction-level model of the expected banks.
module tb_vector_operand_loader;

    localparam int W  = 31;
    localparam int N  = 16;
    localparam int LW = $clog2(N + 1);
    localparam longint P = 64'h7FFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_last;
    logic [W-1:0]  vec1 [0:N-1];
    logic [W-1:0]  vec2 [0:N-1];
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_len;

    vector_operand_loader #(
        .WORD_WIDTH  (W),
        .VECTOR_SIZE (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .vec1      (vec1),
        .vec2      (vec2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: expected bank contents built from the accepted beats
    logic [W-1:0] exp_a [N];
    logic [W-1:0] exp_b [N];
    int           cnt;

    typedef struct {
        int                   n;
        logic                 use_last;
        logic [N-1:0][W-1:0]  a;
        logic [N-1:0][W-1:0]  b;
        int                   exp_len;
        longint               exp_dot;
    } vec_t;

    vec_t tbl [3];

    function automatic logic [W-1:0] canon(input logic [W-1:0] x);
        return (x == {W{1'b1}}) ? {W{1'b0}} : x;
    endfunction

    function automatic longint dut_dot();
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s = (s + ((longint'(vec1[i]) * longint'(vec2[i])) % P)) % P;
        end
        return s;
    endfunction

    function automatic longint model_dot();
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s = (s + ((longint'(exp_a[i]) * longint'(exp_b[i])) % P)) % P;
        end
        return s;
    endfunction

    function automatic logic [W-1:0] lanes_or();
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r = r | vec1[i] | vec2[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_vec();
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
    endtask

    // Present one beat and hold it until accepted, bounded
    task automatic put_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles", waited);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (cnt < N) begin
            exp_a[cnt] = canon(a);
            exp_b[cnt] = canon(b);
        end
        cnt++;
    endtask

    task automatic check_banks(input string tag, input int len);
        chk({tag, "_len"}, 64'(out_len), 64'(len));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_a%0d", tag, i), 64'(vec1[i]), 64'(exp_a[i]));
            chk($sformatf("%s_b%0d", tag, i), 64'(vec2[i]), 64'(exp_b[i]));
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_drain_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_len"},       64'(out_len),   64'd0);
        chk({tag, "_drain_lanes"},     64'(lanes_or()), 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 7) == 0) begin
            return {W{1'b1}};
        end else begin
            return W'($urandom);
        end
    endfunction

    initial begin
        // Directed table
        for (int t = 0; t < 3; t++) begin
            tbl[t].n = 0; tbl[t].use_last = 1'b0; tbl[t].a = '0; tbl[t].b = '0;
            tbl[t].exp_len = 0; tbl[t].exp_dot = 0;
        end
        tbl[0].n = 16; tbl[0].use_last = 1'b0; tbl[0].exp_len = 16; tbl[0].exp_dot = 272;
        for (int i = 0; i < N; i++) begin
            tbl[0].a[i] = W'(i + 1);
            tbl[0].b[i] = W'(2);
        end
        tbl[1].n = 3; tbl[1].use_last = 1'b1; tbl[1].exp_len = 3; tbl[1].exp_dot = 42;
        tbl[1].a[0] = 31'd5; tbl[1].b[0] = 31'd7;
        tbl[1].a[1] = 31'd1; tbl[1].b[1] = 31'd1;
        tbl[1].a[2] = 31'd2; tbl[1].b[2] = 31'd3;
        tbl[2].n = 1; tbl[2].use_last = 1'b1; tbl[2].exp_len = 1; tbl[2].exp_dot = 0;
        tbl[2].a[0] = 31'h7FFF_FFFF; tbl[2].b[0] = 31'd9;

        // Reset state
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready",  64'(in_ready),   64'd1);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_len",       64'(out_len),    64'd0);
        chk("rst_lanes",     64'(lanes_or()), 64'd0);
        reset = 1'b1;
        tick();

        // Table-driven vectors
        for (int t = 0; t < 3; t++) begin
            start_vec();
            for (int i = 0; i < tbl[t].n; i++) begin
                put_beat(tbl[t].a[i], tbl[t].b[i], tbl[t].use_last && (i == tbl[t].n - 1));
            end
            chk($sformatf("t%0d_out_valid", t), 64'(out_valid), 64'd1);
            chk($sformatf("t%0d_in_ready", t),  64'(in_ready),  64'd0);
            check_banks($sformatf("t%0d", t), tbl[t].exp_len);
            chk($sformatf("t%0d_dot", t), 64'(dut_dot()), 64'(tbl[t].exp_dot));
            drain($sformatf("t%0d", t));
        end

        // Backpressure: held beat while FULL must not be taken, then lands in lane 0
        start_vec();
        put_beat(31'd3, 31'd4, 1'b0);
        put_beat(31'd6, 31'd8, 1'b1);
        in_valid = 1'b1; in_a = 31'd11; in_b = 31'd12; in_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            chk($sformatf("bp_hold_c%0d", c),
                {vec1[0], vec2[0], 2'b00}, {exp_a[0], exp_b[0], 2'b00});
            tick();
        end
        check_banks("bp", 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_in_ready", 64'(in_ready),   64'd1);
        chk("bp_rel_lanes",    64'(lanes_or()), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_held_a0", 64'(vec1[0]), 64'd11);
        chk("bp_held_b0", 64'(vec2[0]), 64'd12);
        chk("bp_held_fill", 64'(out_valid), 64'd0);
        start_vec();
        exp_a[0] = 31'd11; exp_b[0] = 31'd12; cnt = 1;
        put_beat(31'd13, 31'd14, 1'b1);
        check_banks("bp2", 2);
        drain("bp2");

        // Reset mid-fill discards the partial vector
        start_vec();
        for (int i = 0; i < 7; i++) begin
            put_beat(W'(100 + i), W'(200 + i), 1'b0);
        end
        reset = 1'b0;
        #2;
        chk("mr_in_ready",  64'(in_ready),   64'd1);
        chk("mr_out_valid", 64'(out_valid),  64'd0);
        chk("mr_len",       64'(out_len),    64'd0);
        chk("mr_lanes",     64'(lanes_or()), 64'd0);
        reset = 1'b1;
        tick();
        start_vec();
        put_beat(31'd21, 31'd22, 1'b0);
        put_beat(31'd23, 31'd24, 1'b1);
        chk("mr_out_valid2", 64'(out_valid), 64'd1);
        check_banks("mr", 2);
        drain("mr");

        // Bubbled input with junk in_last on idle cycles
        start_vec();
        for (int i = 0; i < N; i++) begin
            put_beat(W'(50 + i), W'(70 + i), 1'b0);
            in_valid = 1'b0; in_last = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            if (i < N - 1) begin
                tick();
            end
        end
        in_last = 1'b0;
        chk("bub_out_valid", 64'(out_valid), 64'd1);
        check_banks("bub", 16);
        drain("bub");

        // Randomized vectors against the model
        for (int v = 0; v < 30; v++) begin
            int len;
            logic use_last;
            len = int'($urandom_range(1, N));
            use_last = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
            start_vec();
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
                    in_last = 1'($urandom_range(0, 1));
                    tick();
                end
                put_beat(rnd_word(), rnd_word(), use_last && (i == len - 1));
            end
            chk($sformatf("r%0d_out_valid", v), 64'(out_valid), 64'd1);
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_last = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            check_banks($sformatf("r%0d", v), len);
            chk($sformatf("r%0d_dot", v), 64'(dut_dot()), 64'(model_dot()));
            drain($sformatf("r%0d", v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
